// File: rtl/tictactoe_pkg.sv
// Shared tic-tac-toe types and constants: cell encoding, judge FSM states
// and the table of the eight win lines as 1-based cell indices.
package tictactoe_pkg;

    localparam int unsigned NUM_LINES = 8;
    localparam int unsigned CELL_W    = 2;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned LINE_W    = 3;

    typedef enum logic [CELL_W-1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10,
        BAD   = 2'b11
    } cell_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } judge_state_t;

    // Rows, then columns, then main and anti diagonal
    localparam logic [IDX_W-1:0] LINES [NUM_LINES][3] = '{
        '{4'd1, 4'd2, 4'd3},
        '{4'd4, 4'd5, 4'd6},
        '{4'd7, 4'd8, 4'd9},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd3, 4'd6, 4'd9},
        '{4'd1, 4'd5, 4'd9},
        '{4'd3, 4'd5, 4'd7}
    };

endpackage

// File: rtl/board_judge_line_check.sv
// Combinational test of one win line: three equal, non-empty cells.
module line_check
    import tictactoe_pkg::*;
(
    input  cell_t a,
    input  cell_t b,
    input  cell_t c,
    output logic  match,
    output cell_t owner
);

    assign match = (a != EMPTY) && (a == b) && (b == c);
    assign owner = match ? a : EMPTY;

endmodule

// File: rtl/board_judge.sv
// Board evaluator: snapshots the nine cells on start, scans the win lines
// one per cycle and reports winner / line / draw / error with a done pulse.
module board_judge
    import tictactoe_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [CELL_W-1:0]   pos1,
    input  logic [CELL_W-1:0]   pos2,
    input  logic [CELL_W-1:0]   pos3,
    input  logic [CELL_W-1:0]   pos4,
    input  logic [CELL_W-1:0]   pos5,
    input  logic [CELL_W-1:0]   pos6,
    input  logic [CELL_W-1:0]   pos7,
    input  logic [CELL_W-1:0]   pos8,
    input  logic [CELL_W-1:0]   pos9,
    output logic                busy,
    output logic                done,
    output logic [CELL_W-1:0]   winner,
    output logic [LINE_W-1:0]   winLine,
    output logic                draw,
    output logic                error
);

    judge_state_t      state;
    logic [LINE_W-1:0] k;
    cell_t             snap [1:9];
    cell_t             cur  [1:9];
    logic              any_bad;
    logic              full;
    logic              match;
    cell_t             owner;

    assign cur[1] = cell_t'(pos1);
    assign cur[2] = cell_t'(pos2);
    assign cur[3] = cell_t'(pos3);
    assign cur[4] = cell_t'(pos4);
    assign cur[5] = cell_t'(pos5);
    assign cur[6] = cell_t'(pos6);
    assign cur[7] = cell_t'(pos7);
    assign cur[8] = cell_t'(pos8);
    assign cur[9] = cell_t'(pos9);

    // Illegal cells are detected on the live inputs, the same edge they are captured
    always_comb begin
        any_bad = 1'b0;
        full    = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            if (cur[i] == BAD)
                any_bad = 1'b1;
            if (snap[i] == EMPTY)
                full = 1'b0;
        end
    end

    line_check u_line_check (
        .a     (snap[LINES[k][0]]),
        .b     (snap[LINES[k][1]]),
        .c     (snap[LINES[k][2]]),
        .match (match),
        .owner (owner)
    );

    // done is set on entry to REPORT; busy covers every non-IDLE cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            k       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            winner  <= '0;
            winLine <= '0;
            draw    <= 1'b0;
            error   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snap    <= cur;
                        k       <= '0;
                        busy    <= 1'b1;
                        winner  <= '0;
                        winLine <= '0;
                        draw    <= 1'b0;
                        error   <= any_bad;
                        done    <= any_bad;
                        state   <= any_bad ? REPORT : SCAN;
                    end
                end
                SCAN: begin
                    if (match) begin
                        winner  <= CELL_W'(owner);
                        winLine <= k;
                        done    <= 1'b1;
                        state   <= REPORT;
                    end else if (k == LINE_W'(NUM_LINES - 1)) begin
                        draw  <= full;
                        done  <= 1'b1;
                        state <= REPORT;
                    end else begin
                        k <= k + LINE_W'(1);
                    end
                end
                REPORT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_judge.sv
// Self-checking bench for board_judge: a cycle-level behavioural model of the
// evaluation result and latency, directed scenarios and randomized traffic.
module tb_board_judge;

    logic       clock;
    logic       reset;
    logic       start;
    logic [1:0] board [9];
    logic       busy, done, draw, error;
    logic [1:0] winner;
    logic [2:0] winLine;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 0;

    board_judge dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .pos1    (board[0]),
        .pos2    (board[1]),
        .pos3    (board[2]),
        .pos4    (board[3]),
        .pos5    (board[4]),
        .pos6    (board[5]),
        .pos7    (board[6]),
        .pos8    (board[7]),
        .pos9    (board[8]),
        .busy    (busy),
        .done    (done),
        .winner  (winner),
        .winLine (winLine),
        .draw    (draw),
        .error   (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference evaluation: latency in cycles from the accepting edge to done
    function automatic void eval(input logic [1:0] bd [9], output int lat,
                                 output logic [1:0] w, output logic [2:0] wl,
                                 output logic d, output logic e);
        int a, b, c;
        w = 2'd0; wl = 3'd0; d = 1'b0; e = 1'b0;
        for (int i = 0; i < 9; i++)
            if (bd[i] == 2'b11) e = 1'b1;
        if (e) begin
            lat = 1;
            return;
        end
        for (int ln = 0; ln < 8; ln++) begin
            if (ln < 3) begin
                a = 3 * ln; b = a + 1; c = a + 2;
            end else if (ln < 6) begin
                a = ln - 3; b = a + 3; c = a + 6;
            end else if (ln == 6) begin
                a = 0; b = 4; c = 8;
            end else begin
                a = 2; b = 4; c = 6;
            end
            if (bd[a] != 2'b00 && bd[a] == bd[b] && bd[b] == bd[c]) begin
                w   = bd[a];
                wl  = 3'(ln);
                lat = ln + 2;
                return;
            end
        end
        d = 1'b1;
        for (int i = 0; i < 9; i++)
            if (bd[i] == 2'b00) d = 1'b0;
        lat = 9;
    endfunction

    // Cycle model: rem counts cycles left in the current evaluation
    int         rem = 0;
    int         r_lat;
    logic [1:0] r_w,  m_w  = 2'd0;
    logic [2:0] r_wl, m_wl = 3'd0;
    logic       r_d,  m_d  = 1'b0;
    logic       r_e,  m_e  = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            rem = 0;
            m_w = 2'd0; m_wl = 3'd0; m_d = 1'b0; m_e = 1'b0;
        end else if (rem == 0) begin
            if (start) begin
                eval(board, r_lat, r_w, r_wl, r_d, r_e);
                rem = r_lat;
                m_w = 2'd0; m_wl = 3'd0; m_d = 1'b0; m_e = 1'b0;
                if (rem == 1) begin
                    m_w = r_w; m_wl = r_wl; m_d = r_d; m_e = r_e;
                end
            end
        end else begin
            rem--;
            if (rem == 1) begin
                m_w = r_w; m_wl = r_wl; m_d = r_d; m_e = r_e;
            end
        end
    end

    always @(negedge clock) begin
        if (checking) begin
            chk("busy",    int'(busy),    int'(rem > 0));
            chk("done",    int'(done),    int'(rem == 1));
            chk("winner",  int'(winner),  int'(m_w));
            chk("winLine", int'(winLine), int'(m_wl));
            chk("draw",    int'(draw),    int'(m_d));
            chk("error",   int'(error),   int'(m_e));
        end
    end

    // pos1 occupies the top two bits
    task automatic set_board(input logic [17:0] v);
        for (int i = 0; i < 9; i++)
            board[i] = v[17 - 2*i -: 2];
    endtask

    task automatic pin_model(input string name, input logic [17:0] v, input int lat,
                             input int w, input int wl, input int d, input int e);
        logic [1:0] bd [9];
        int         g_lat;
        logic [1:0] g_w;
        logic [2:0] g_wl;
        logic       g_d, g_e;
        for (int i = 0; i < 9; i++)
            bd[i] = v[17 - 2*i -: 2];
        eval(bd, g_lat, g_w, g_wl, g_d, g_e);
        chk({name, " model lat"},  g_lat,      lat);
        chk({name, " model w"},    int'(g_w),  w);
        chk({name, " model line"}, int'(g_wl), wl);
        chk({name, " model draw"}, int'(g_d),  d);
        chk({name, " model err"},  int'(g_e),  e);
    endtask

    // Called #1 after a posedge with the DUT idle
    task automatic run_case(input string name, input logic [17:0] v, input int lat,
                            input int w, input int wl, input int d, input int e);
        int cyc;
        set_board(v);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 20) begin
            @(posedge clock); #1;
            cyc++;
        end
        chk({name, " latency"}, cyc, lat);
        chk({name, " winner"},  int'(winner),  w);
        chk({name, " winLine"}, int'(winLine), wl);
        chk({name, " draw"},    int'(draw),    d);
        chk({name, " error"},   int'(error),   e);
        @(posedge clock); #1;
    endtask

    function automatic logic [1:0] rnd_cell();
        int v;
        v = int'($urandom_range(0, 15));
        if (v == 0) return 2'b11;
        return 2'(v % 3);
    endfunction

    initial begin
        reset = 1'b1;
        start = 1'b0;
        set_board(18'd0);

        pin_model("row0",  18'b01_01_01_00_00_00_00_00_00, 2, 1, 0, 0, 0);
        pin_model("anti",  18'b01_00_10_00_10_00_10_00_00, 9, 2, 7, 0, 0);
        pin_model("draw",  18'b01_10_01_01_10_10_10_01_01, 9, 0, 0, 1, 0);
        pin_model("err",   18'b00_00_00_00_11_00_00_00_00, 1, 0, 0, 0, 1);

        @(posedge clock); #1;
        checking = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("reset busy",   int'(busy),   0);
        chk("reset done",   int'(done),   0);
        chk("reset winner", int'(winner), 0);

        run_case("row win",  18'b01_01_01_00_00_00_00_00_00, 2, 1, 0, 0, 0);
        run_case("anti win", 18'b01_00_10_00_10_00_10_00_00, 9, 2, 7, 0, 0);
        run_case("draw",     18'b01_10_01_01_10_10_10_01_01, 9, 0, 0, 1, 0);
        run_case("error",    18'b00_00_00_00_11_00_00_00_00, 1, 0, 0, 0, 1);
        run_case("col win",  18'b00_10_00_01_10_00_00_10_01, 6, 2, 4, 0, 0);

        // Snapshot isolation and start ignored while busy
        set_board(18'b00_00_00_01_01_01_00_00_00);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        board[3] = 2'b00;
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("snap done",    int'(done),    1);
        chk("snap winner",  int'(winner),  1);
        chk("snap winLine", int'(winLine), 1);
        @(posedge clock); #1;
        chk("snap idle1", int'(busy), 0);
        @(posedge clock); #1;
        chk("snap idle2", int'(busy), 0);

        // Reset in the middle of a long scan
        set_board(18'd0);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("mid reset busy", int'(busy), 0);
        chk("mid reset done", int'(done), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        run_case("after reset", 18'b10_01_00_10_01_00_10_00_00, 5, 2, 3, 0, 0);

        // Randomized traffic checked every cycle by the model
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0)
                for (int j = 0; j < 9; j++)
                    board[j] = rnd_cell();
            @(posedge clock); #1;
        end
        reset = 1'b0;
        start = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        checking = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
